mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Sits beside the X-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from X.
- Supplies HI/LO to D-stage reads (MFHI/MFLO).
- Raises a stall request while a dependent instruction must wait on an in-flight operation.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits; must be even and at least 4.
- STEPS_PER_CYCLE, 1: radix-2 iterations per cycle; must divide WIDTH. N = WIDTH/STEPS_PER_CYCLE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on the next rising clk edge).
- en  input  1  global enable; en=0 freezes all state and holds every output.
- start  input  1  X-stage op valid; sampled only while en=1.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6 and 7 reserved (see Optional Feature).
- op_a  input  WIDTH  rs operand.
- op_b  input  WIDTH  rt operand.
- flush  input  1  kill the in-flight op; HI/LO are left unchanged.
- rd_req  input  1  D stage holds MFHI/MFLO.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse when HI/LO are written by MULT/DIV.
- stall  output  1  = busy & (start | rd_req).

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; hi=0; lo=0; busy=0; done=0; counter=0; all internal registers=0. Reset overrides en, start and flush, and aborts any in-flight op.
- States: IDLE, MUL, DIV, FIXUP.
- IDLE with start & en:
  - MULT/MULTU: latch operands, go to MUL, counter=N.
  - DIV/DIVU: latch operands, go to DIV, counter=N.
  - MTHI: hi<=op_a next edge, stay IDLE, no done. MTLO likewise updates lo.
- Operand latching:
  - Signed ops (MULT, DIV) latch magnitudes plus result sign flags.
  - Unsigned ops latch raw operands.
  - Magnitude of the most-negative value is 2^(WIDTH-1), held in a WIDTH+1-bit internal register.
- MUL: shift-add, STEPS_PER_CYCLE bits per cycle, into a 2*WIDTH accumulator. counter decrements; at counter=1 go to FIXUP.
- DIV: restoring divide producing STEPS_PER_CYCLE quotient bits per cycle. counter decrements; at counter=1 go to FIXUP.
- FIXUP:
  - Apply signs. Product is negated if signs differ. Quotient is negated if signs differ. Remainder takes the dividend's sign.
  - Write {hi,lo} = product[2W-1:W], product[W-1:0]; for divide, hi=remainder, lo=quotient.
  - done=1 this cycle; return to IDLE.
- Latency: start accepted at edge 0; busy=1 during cycles 1..N+1; done in cycle N+1; new hi/lo visible from cycle N+2.
- busy=1 in MUL, DIV and FIXUP.
- Divide by zero (op_b=0): hi=op_a, lo={WIDTH{1'b1}}, regardless of signedness. Same latency as a normal divide.
- Signed overflow (MIN / -1): lo=MIN, hi=0.
- start while busy: not accepted; stall=1. The X stage holds the op until busy drops; the op is accepted in the first IDLE cycle.
- rd_req while busy: stall=1. rd_req with done=1 still stalls; the read proceeds the next cycle and sees new values.
- flush:
  - Any non-IDLE state goes to IDLE next edge; busy=0, done=0, HI/LO untouched.
  - flush together with start in IDLE: the op is dropped, including MTHI/MTLO.
- hi/lo change only at FIXUP, MTHI/MTLO, or reset.

Optional Feature:
- Macro MIPS_MULDIV_MADD_EN.
- Defined:
  - op 6 = MADD: {hi,lo} += signed op_a*op_b.
  - op 7 = MSUB: {hi,lo} -= signed op_a*op_b.
  - Same latency as MULT plus one extra FIXUP cycle (FIXUP2), so done arrives in cycle N+2.
  - Sum/difference wraps modulo 2^(2*WIDTH).
- Undefined: ops 6/7 are treated as NOP; not accepted, no busy, no state change.

Test Plan:
- Reset: drive rst=0 for 2 cycles with start=1 -> hi=0, lo=0, busy=0, done=0, stall=0.
- WIDTH=32, STEPS=1, MULT op_a=0xFFFFFFFD (-3), op_b=7 -> done in cycle 33 after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU 7/0 -> hi=7, lo=0xFFFFFFFF.
- During MULTU 0xFFFFFFFF*0xFFFFFFFF: hold rd_req=1 -> stall=1 through cycle 33. Result hi=0xFFFFFFFE, lo=0x00000001, readable in cycle 34.
- Start DIV, assert flush in cycle 5 -> busy=0 in cycle 6, no done pulse, hi/lo keep prior values. Then MTLO 0x1234 -> lo=0x1234 next cycle, busy stays 0.
- STEPS=4, en toggled 0 for 3 cycles mid-MULT 0x10000*0x10000 -> done delayed exactly 3 cycles (cycle 12); hi=1, lo=0.

Source files
------------

// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if
//   Connection between the X/D pipeline stages (master) and the
//   iterative multiply/divide unit (slave).
//
//   en      global enable, 0 freezes the unit
//   start   X-stage op valid
//   op      0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MADD 7=MSUB
//   op_a    rs operand
//   op_b    rt operand
//   flush   kill the in-flight op
//   rd_req  D stage holds MFHI/MFLO
//   hi, lo  HI/LO registers
//   busy    iterative operation in progress
//   done    one-cycle pulse when HI/LO are written by MULT/DIV
//   stall   busy & (start | rd_req)
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             rd_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output en, start, op, op_a, op_b, flush, rd_req,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  en, start, op, op_a, op_b, flush, rd_req,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative multiply/divide unit with HI/LO registers for the pipelined
//   MIPS core. MULT/MULTU use shift-add, DIV/DIVU use restoring division,
//   both retiring STEPS_PER_CYCLE radix-2 steps per clock. Signed ops work
//   on magnitudes; signs are applied in the FIXUP cycle.
//
//   Optional feature: define MIPS_MULDIV_MADD_EN to enable op 6 (MADD) and
//   op 7 (MSUB), which accumulate a signed product into {hi,lo} through an
//   extra FIXUP2 cycle. Without the macro ops 6/7 are ignored.
//
//   Parameters
//     WIDTH            operand / HI / LO width (even, >= 4)
//     STEPS_PER_CYCLE  radix-2 iterations per clock (divides WIDTH)
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-low reset
//     bus   mips_muldiv_if slave modport (en, start, op, op_a, op_b,
//           flush, rd_req in; hi, lo, busy, done, stall out)
module mips_muldiv_unit #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    mips_muldiv_if.slave  bus
);

    localparam int N     = WIDTH / STEPS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam int AW    = 2 * WIDTH + 1;

    localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MUL    = 3'd1;
    localparam logic [2:0] S_DIV    = 3'd2;
    localparam logic [2:0] S_FIXUP  = 3'd3;
`ifdef MIPS_MULDIV_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;
    localparam logic [2:0] S_FIXUP2 = 3'd4;
`endif

    // Two's-complement negate when neg is set (also gives |v| for a
    // negative v, with the most-negative value mapping to 2^(WIDTH-1)).
    function automatic logic [WIDTH-1:0] neg_cond_w(input logic [WIDTH-1:0] v,
                                                   input logic neg);
        return neg ? ((~v) + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_cond_2w(input logic [2*WIDTH-1:0] v,
                                                      input logic neg);
        return neg ? ((~v) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    logic [2:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    // MUL: {upper partial product (W+1), multiplier/low product (W)}
    // DIV: {partial remainder (W+1), dividend/quotient (W)}
    logic [AW-1:0]    acc_q;
    // multiplicand or divisor magnitude
    logic [WIDTH:0]   opd_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             is_div_q;
    logic             div0_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
`ifdef MIPS_MULDIV_MADD_EN
    logic             madd_q;
    logic             msub_q;
`endif

    // Operand conditioning for the op being offered in IDLE
    logic             signed_op;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
`ifdef MIPS_MULDIV_MADD_EN
        signed_op = signed_op || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
`endif
        sign_a = signed_op & bus.op_a[WIDTH-1];
        sign_b = signed_op & bus.op_b[WIDTH-1];
        mag_a  = neg_cond_w(bus.op_a, sign_a);
        mag_b  = neg_cond_w(bus.op_b, sign_b);
    end

    // One clock's worth of shift-add and restoring-divide steps
    logic [AW-1:0]  mul_acc;
    logic [AW-1:0]  div_acc;
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH+1:0] div_diff;

    always_comb begin
        mul_acc   = acc_q;
        div_acc   = acc_q;
        mul_sum   = '0;
        div_shift = '0;
        div_diff  = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            // Upper field stays below 2^WIDTH after each shift, so the sum
            // with a WIDTH-bit magnitude never overflows WIDTH+1 bits.
            mul_sum = mul_acc[AW-1:WIDTH] + (mul_acc[0] ? opd_q : '0);
            mul_acc = {1'b0, mul_sum, mul_acc[WIDTH-1:1]};

            // Remainder is always below the divisor, so its top bit is zero
            // and the shifted value fits WIDTH+1 bits.
            div_shift = div_acc[2*WIDTH-1:WIDTH-1];
            div_diff  = {1'b0, div_shift} - {1'b0, opd_q};
            if (!div_diff[WIDTH+1])
                div_acc = {div_diff[WIDTH:0], div_acc[WIDTH-2:0], 1'b1};
            else
                div_acc = {div_shift, div_acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign application for the FIXUP cycle
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    always_comb begin
        prod_s = neg_cond_2w(acc_q[2*WIDTH-1:0], neg_res_q);
        // Divide by zero leaves the raw dividend as remainder, which the
        // dividend-sign rule turns back into op_a.
        quo_s  = div0_q ? {WIDTH{1'b1}} : neg_cond_w(acc_q[WIDTH-1:0], neg_res_q);
        rem_s  = neg_cond_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MIPS_MULDIV_MADD_EN
            madd_q    <= 1'b0;
            msub_q    <= 1'b0;
`endif
        end else if (bus.en) begin
            if (bus.flush) begin
                // Kills any in-flight op, and drops an op offered in IDLE
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            case (bus.op)
                                OP_MULT, OP_MULTU: begin
                                    state_q   <= S_MUL;
                                    cnt_q     <= CNT_N;
                                    acc_q     <= {{(WIDTH+1){1'b0}}, mag_a};
                                    opd_q     <= {1'b0, mag_b};
                                    neg_res_q <= sign_a ^ sign_b;
                                    neg_rem_q <= 1'b0;
                                    is_div_q  <= 1'b0;
                                    div0_q    <= 1'b0;
`ifdef MIPS_MULDIV_MADD_EN
                                    madd_q    <= 1'b0;
                                    msub_q    <= 1'b0;
`endif
                                end
                                OP_DIV, OP_DIVU: begin
                                    state_q   <= S_DIV;
                                    cnt_q     <= CNT_N;
                                    acc_q     <= {{(WIDTH+1){1'b0}}, mag_a};
                                    opd_q     <= {1'b0, mag_b};
                                    neg_res_q <= sign_a ^ sign_b;
                                    neg_rem_q <= sign_a;
                                    is_div_q  <= 1'b1;
                                    div0_q    <= (bus.op_b == '0);
`ifdef MIPS_MULDIV_MADD_EN
                                    madd_q    <= 1'b0;
                                    msub_q    <= 1'b0;
`endif
                                end
                                OP_MTHI: hi_q <= bus.op_a;
                                OP_MTLO: lo_q <= bus.op_a;
`ifdef MIPS_MULDIV_MADD_EN
                                OP_MADD, OP_MSUB: begin
                                    state_q   <= S_MUL;
                                    cnt_q     <= CNT_N;
                                    acc_q     <= {{(WIDTH+1){1'b0}}, mag_a};
                                    opd_q     <= {1'b0, mag_b};
                                    neg_res_q <= sign_a ^ sign_b;
                                    neg_rem_q <= 1'b0;
                                    is_div_q  <= 1'b0;
                                    div0_q    <= 1'b0;
                                    madd_q    <= (bus.op == OP_MADD);
                                    msub_q    <= (bus.op == OP_MSUB);
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        acc_q <= mul_acc;
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE)
                            state_q <= S_FIXUP;
                    end
                    S_DIV: begin
                        acc_q <= div_acc;
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE)
                            state_q <= S_FIXUP;
                    end
                    S_FIXUP: begin
`ifdef MIPS_MULDIV_MADD_EN
                        if (madd_q || msub_q) begin
                            // Park the signed product for the accumulate cycle
                            acc_q   <= {1'b0, prod_s};
                            state_q <= S_FIXUP2;
                        end else
`endif
                        begin
                            if (is_div_q) begin
                                hi_q <= rem_s;
                                lo_q <= quo_s;
                            end else begin
                                hi_q <= prod_s[2*WIDTH-1:WIDTH];
                                lo_q <= prod_s[WIDTH-1:0];
                            end
                            state_q <= S_IDLE;
                        end
                    end
`ifdef MIPS_MULDIV_MADD_EN
                    S_FIXUP2: begin
                        if (msub_q)
                            {hi_q, lo_q} <= {hi_q, lo_q} - acc_q[2*WIDTH-1:0];
                        else
                            {hi_q, lo_q} <= {hi_q, lo_q} + acc_q[2*WIDTH-1:0];
                        state_q <= S_IDLE;
                    end
`endif
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Cycle in which HI/LO are written; a flush in that cycle cancels the
    // write, so the pulse is suppressed too.
    logic fin;
`ifdef MIPS_MULDIV_MADD_EN
    assign fin = ((state_q == S_FIXUP) && !(madd_q || msub_q)) || (state_q == S_FIXUP2);
`else
    assign fin = (state_q == S_FIXUP);
`endif

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = fin & ~(bus.en & bus.flush);
    assign bus.stall = bus.busy & (bus.start | bus.rd_req);

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit
//   Drives identical stimulus into a 1-step and a 4-step instance and
//   compares both against an arithmetic reference of HI/LO.
module tb_mips_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, start, flush, rd_req;
    logic [2:0]  op;
    logic [31:0] op_a, op_b;

    always #5 clk = ~clk;

    mips_muldiv_if #(.WIDTH(32)) bus1 ();
    mips_muldiv_if #(.WIDTH(32)) bus4 ();

    assign bus1.en = en;   assign bus4.en = en;
    assign bus1.start = start; assign bus4.start = start;
    assign bus1.op = op;   assign bus4.op = op;
    assign bus1.op_a = op_a; assign bus4.op_a = op_a;
    assign bus1.op_b = op_b; assign bus4.op_b = op_b;
    assign bus1.flush = flush; assign bus4.flush = flush;
    assign bus1.rd_req = rd_req; assign bus4.rd_req = rd_req;

    mips_muldiv_unit #(.WIDTH(32), .STEPS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    mips_muldiv_unit #(.WIDTH(32), .STEPS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one op on HI/LO
    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            3'd0: begin p = sa * sb; {m_hi, m_lo} = p; end
            3'd1: begin up = ua * ub; {m_hi, m_lo} = up; end
            3'd2: begin
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin p = sa / sb; m_lo = p[31:0]; p = sa % sb; m_hi = p[31:0]; end
            end
            3'd3: begin
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0]; end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
`ifdef MIPS_MULDIV_MADD_EN
            3'd6: begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; end
            3'd7: begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} - p; end
`endif
            default: ;
        endcase
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = $urandom_range(0, 20);
            3: v = -$urandom_range(1, 20);
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Issue one iterative op, check done latency for both instances and the
    // resulting HI/LO in the cycle after done.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        int d1, d4, lat1, lat4;
        bit st_ok;
        lat1 = 33;
        lat4 = 9;
`ifdef MIPS_MULDIV_MADD_EN
        if (o >= 3'd6) begin lat1 = 34; lat4 = 10; end
`endif
        model_op(o, a, b);
        op = o; op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check({tag, "_busy"}, bus1.busy, 1);
        d1 = 0; d4 = 0; st_ok = 1'b1;
        for (int c = 1; c <= lat1 + 5; c++) begin
            if (rd_req && !bus1.stall) st_ok = 1'b0;
            if (bus4.done && d4 == 0) d4 = c;
            if (bus1.done) begin d1 = c; break; end
            tick();
        end
        check({tag, "_lat1"}, d1, lat1);
        check({tag, "_lat4"}, d4, lat4);
        if (rd_req) check({tag, "_stall_held"}, st_ok, 1);
        tick();
        check({tag, "_hi1"}, bus1.hi, m_hi);
        check({tag, "_lo1"}, bus1.lo, m_lo);
        check({tag, "_hi4"}, bus4.hi, m_hi);
        check({tag, "_lo4"}, bus4.lo, m_lo);
        check({tag, "_idle"}, {bus1.busy, bus1.done}, 2'b00);
        if (rd_req) check({tag, "_stall_rel"}, bus1.stall, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] xa, xb, xv, e_hi, e_lo;
        int d1, d4;
        bit seen;

        rst = 1'b0; en = 1'b1; start = 1'b1; op = 3'd0;
        op_a = 32'd5; op_b = 32'd3; flush = 1'b0; rd_req = 1'b0;
        tick(); tick();
        check("rst_hi", bus1.hi, 0);
        check("rst_lo", bus1.lo, 0);
        check("rst_ctl1", {bus1.busy, bus1.done, bus1.stall}, 3'b000);
        check("rst_ctl4", {bus4.busy, bus4.done, bus4.stall}, 3'b000);
        rst = 1'b1; start = 1'b0;

        run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd7);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("divu0", 3'd3, 32'd7, 32'd0);
        rd_req = 1'b1;
        run_op("multu_rd", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_req = 1'b0;
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div0_neg", 3'd2, 32'h8000_0005, 32'd0);
        run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000);
        run_op("div_nn", 3'd2, -32'd100, -32'd7);

        for (int i = 0; i < 24; i++) begin
            xa = pick();
            xb = pick();
            run_op("rand", 3'($urandom_range(0, 3)), xa, xb);
        end

        // X stage holds an MTHI behind a busy MULT; it lands in the first
        // IDLE cycle of each instance.
        xa = 32'd12345; xb = -32'd3; xv = 32'hCAFE_F00D;
        model_op(3'd0, xa, xb);
        e_hi = m_hi; e_lo = m_lo;
        op = 3'd0; op_a = xa; op_b = xb; start = 1'b1;
        tick();
        op = 3'd4; op_a = xv;
        #1;
        check("hold_stall", bus1.stall, 1);
        repeat (33) tick();
        check("hold_idle", {bus1.busy, bus1.stall}, 2'b00);
        check("hold_hi_pre", bus1.hi, e_hi);
        check("hold_lo_pre", bus1.lo, e_lo);
        tick();
        start = 1'b0;
        model_op(3'd4, xv, 32'd0);
        check("hold_hi1", bus1.hi, m_hi);
        check("hold_lo1", bus1.lo, m_lo);
        check("hold_hi4", bus4.hi, m_hi);
        check("hold_lo4", bus4.lo, m_lo);

        // Flush a divide in cycle 5
        seen = 1'b0;
        op = 3'd2; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) begin
            seen |= bus1.done | bus4.done;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_busy", {bus1.busy, bus4.busy}, 2'b00);
        for (int c = 0; c < 40; c++) begin
            seen |= bus1.done | bus4.done;
            tick();
        end
        check("flush_nodone", seen, 0);
        check("flush_hi", bus1.hi, m_hi);
        check("flush_lo", bus1.lo, m_lo);
        check("flush_lo4", bus4.lo, m_lo);

        op = 3'd5; op_a = 32'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        model_op(3'd5, 32'h1234, 32'd0);
        check("mtlo_lo", bus1.lo, m_lo);
        check("mtlo_hi", bus1.hi, m_hi);
        check("mtlo_busy", bus1.busy, 0);

        xv = $urandom();
        op = 3'd4; op_a = xv; start = 1'b1;
        tick();
        start = 1'b0;
        model_op(3'd4, xv, 32'd0);
        check("mthi_hi4", bus4.hi, m_hi);

        // flush alongside start in IDLE drops the op
        op = 3'd4; op_a = ~xv; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_mthi", bus1.hi, m_hi);

`ifdef MIPS_MULDIV_MADD_EN
        run_op("madd", 3'd6, -32'd9, 32'd1000);
        run_op("msub", 3'd7, 32'h7FFF_FFFF, 32'h8000_0000);
`else
        op = 3'd6; op_a = 32'd5; op_b = 32'd7; start = 1'b1;
        tick();
        check("nop6_busy", bus1.busy, 0);
        op = 3'd7;
        tick();
        start = 1'b0;
        check("nop7_busy", bus4.busy, 0);
        check("nop_hi", bus1.hi, m_hi);
        check("nop_lo", bus1.lo, m_lo);
`endif

        // en held low for cycles 3..5 of a multiply
        model_op(3'd0, 32'h0001_0000, 32'h0001_0000);
        op = 3'd0; op_a = 32'h0001_0000; op_b = 32'h0001_0000; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        en = 1'b0;
        tick(); tick();
        check("en_hold_busy", bus4.busy, 1);
        tick();
        en = 1'b1;
        d1 = 0; d4 = 0;
        for (int c = 6; c <= 60; c++) begin
            if (bus4.done && d4 == 0) d4 = c;
            if (bus1.done) begin d1 = c; break; end
            tick();
        end
        check("en_lat4", d4, 12);
        check("en_lat1", d1, 36);
        tick();
        check("en_hi4", bus4.hi, m_hi);
        check("en_lo4", bus4.lo, m_lo);
        check("en_hi1", bus1.hi, m_hi);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
